// File: rtl/subneg_loader.sv
// subneg_loader: pin-driven program loader for the subneg CPU core.
// Receives an image word-by-word on ld_data with a slow strobe handshake,
// writes it into the core memory and holds the core stopped until done.
// Optional feature macro: SUBNEG_LOADER_CHECKSUM_EN (adds a trailing
// checksum word and the CHECK state).
module subneg_loader #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 5,
    parameter int MEM_WORDS = 22
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_mode,
    input  logic              ld_strobe,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_run,
    output logic              ld_busy,
    output logic              ld_error
);

`ifdef SUBNEG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } state_t;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(MEM_WORDS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);
    localparam logic [1:0]        SETTLE_LAST = 2'd3;

    // Modulo-2^DATA_W running checksum step.
    function automatic logic [DATA_W-1:0] sum_add(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

    state_t            state_r;
    state_t            next_s;
    logic [2:0]        mode_sync_r;
    logic [2:0]        strb_sync_r;
    logic [1:0]        settle_r;
    logic [ADDR_W-1:0] addr_r;
`ifdef SUBNEG_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_r;
`endif
    logic              mode_s;
    logic              mode_rise_s;
    logic              rise_s;
    logic              wr_s;
    logic              load_entry_s;
    logic              run_nx_s;
    logic              busy_nx_s;
    logic              err_nx_s;

    // Synchronise the asynchronous mode and strobe pins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_sync_r <= 3'b000;
            strb_sync_r <= 3'b000;
        end else begin
            mode_sync_r <= {mode_sync_r[1:0], ld_mode};
            strb_sync_r <= {strb_sync_r[1:0], ld_strobe};
        end
    end

    assign mode_s      = mode_sync_r[1];
    assign mode_rise_s = mode_sync_r[1] & ~mode_sync_r[2];
    assign rise_s      = strb_sync_r[1] & ~strb_sync_r[2];
    assign wr_s        = (state_r == ST_LOAD) && mode_s && rise_s;
    assign load_entry_s = (next_s == ST_LOAD) && (state_r != ST_LOAD);

    // Settle counter: lets the mode synchroniser fill before IDLE decides.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_r <= 2'd0;
        end else if ((state_r == ST_IDLE) && (settle_r != SETTLE_LAST)) begin
            settle_r <= settle_r + 2'd1;
        end else begin
            settle_r <= settle_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // FSM next-state logic; abort (mode low) overrides any strobe.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (settle_r == SETTLE_LAST) begin
                    next_s = mode_s ? ST_LOAD : ST_RUN;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (!mode_s) begin
                    next_s = ST_ERROR;
                end else if (rise_s && (addr_r == LAST_ADDR)) begin
`ifdef SUBNEG_LOADER_CHECKSUM_EN
                    next_s = ST_CHECK;
`else
                    next_s = ST_RUN;
`endif
                end else begin
                    next_s = ST_LOAD;
                end
            end
`ifdef SUBNEG_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (!mode_s) begin
                    next_s = ST_ERROR;
                end else if (rise_s) begin
                    next_s = (ld_data == sum_r) ? ST_RUN : ST_ERROR;
                end else begin
                    next_s = ST_CHECK;
                end
            end
`endif
            ST_RUN, ST_ERROR: begin
                if (mode_rise_s) begin
                    next_s = ST_LOAD;
                end else begin
                    next_s = state_r;
                end
            end
            default: next_s = ST_IDLE;
        endcase
    end

    // FSM output decode from the next state, so flags move with the state.
    always_comb begin
        run_nx_s  = 1'b0;
        busy_nx_s = 1'b0;
        err_nx_s  = 1'b0;
        case (next_s)
            ST_LOAD:  busy_nx_s = 1'b1;
`ifdef SUBNEG_LOADER_CHECKSUM_EN
            ST_CHECK: busy_nx_s = 1'b1;
`endif
            ST_RUN:   run_nx_s  = 1'b1;
            ST_ERROR: err_nx_s  = 1'b1;
            default: begin
                run_nx_s  = 1'b0;
                busy_nx_s = 1'b0;
                err_nx_s  = 1'b0;
            end
        endcase
    end

    // Registered state flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu_run  <= 1'b0;
            ld_busy  <= 1'b0;
            ld_error <= 1'b0;
        end else begin
            cpu_run  <= run_nx_s;
            ld_busy  <= busy_nx_s;
            ld_error <= err_nx_s;
        end
    end

    // Write datapath: address counter, checksum and the memory write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            addr_r    <= '0;
`ifdef SUBNEG_LOADER_CHECKSUM_EN
            sum_r     <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            if (load_entry_s) begin
                addr_r <= '0;
`ifdef SUBNEG_LOADER_CHECKSUM_EN
                sum_r  <= '0;
`endif
            end else if (wr_s) begin
                mem_we    <= 1'b1;
                mem_addr  <= addr_r;
                mem_wdata <= ld_data;
                // Saturate: the state leaves LOAD at the last word anyway.
                addr_r    <= (addr_r == LAST_ADDR) ? addr_r : addr_r + ADDR_ONE;
`ifdef SUBNEG_LOADER_CHECKSUM_EN
                sum_r     <= sum_add(sum_r, ld_data);
`endif
            end
        end
    end

endmodule

// File: tb/tb_subneg_loader.sv
// Self-checking bench for subneg_loader: directed scenarios plus random
// images, checked against a queue-based model of the expected writes.
module tb_subneg_loader;
    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 5;
    localparam int MEM_WORDS = 22;

`ifdef SUBNEG_LOADER_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] ld_data = '0;
    logic              ld_mode = 1'b0;
    logic              ld_strobe = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_run;
    logic              ld_busy;
    logic              ld_error;

    int errors = 0;
    int checks = 0;
    int we_count = 0;
    int exp_addr_q[$];
    int exp_data_q[$];
    int img[MEM_WORDS];
    int base;

    subneg_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .ld_data(ld_data), .ld_mode(ld_mode),
        .ld_strobe(ld_strobe), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_run(cpu_run), .ld_busy(ld_busy),
        .ld_error(ld_error)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Every write pulse must match the next expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            we_count++;
            if (exp_addr_q.size() == 0) begin
                check_val("unexpected_we", int'(mem_we), 0);
            end else begin
                check_val("we_addr", int'(mem_addr), exp_addr_q.pop_front());
                check_val("we_data", int'(mem_wdata), exp_data_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int outs();
        return int'({mem_we, mem_addr, mem_wdata, cpu_run, ld_busy, ld_error});
    endfunction

    task automatic do_reset(input logic mode);
        rst_n = 1'b0;
        ld_mode = mode;
        ld_strobe = 1'b0;
        ld_data = '0;
        tick();
        check_val("reset_outs", outs(), 0);
        tick();
        rst_n = 1'b1;
    endtask

    // One strobe handshake: 2 cycles data setup, 3 high, 3 low.
    task automatic send_word(input int addr, input int data, input bit expect_write,
                             input bit last_to_run);
        ld_data = DATA_W'(data);
        tick();
        tick();
        ld_strobe = 1'b1;
        if (expect_write) begin
            exp_addr_q.push_back(addr);
            exp_data_q.push_back(data);
        end
        tick();
        tick();
        if (expect_write) check_val("lat_e1_we", int'(mem_we), 0);
        tick();
        if (expect_write) check_val("lat_e2_we", int'(mem_we), 1);
        if (last_to_run) check_val("run_after_last", int'(cpu_run), 1);
        ld_strobe = 1'b0;
        tick();
        if (expect_write) check_val("pulse_width", int'(mem_we), 0);
        tick();
        tick();
    endtask

    // Drop then raise ld_mode; LOAD must be entered on the third edge.
    task automatic start_load(input bit from_run);
        ld_mode = 1'b0;
        repeat (4) tick();
        ld_mode = 1'b1;
        tick();
        tick();
        if (from_run) check_val("run_before_reload", int'(cpu_run), 1);
        tick();
        if (from_run) check_val("run_drop_reload", int'(cpu_run), 0);
        check_val("busy_on_load", int'(ld_busy), 1);
        check_val("err_on_load", int'(ld_error), 0);
        tick();
    endtask

    // Load img[]; abort_at < MEM_WORDS drops ld_mode before that word.
    task automatic load_image(input int abort_at, input bit bad_cs);
        int sum = 0;
        bit aborted = 1'b0;
        bit ok;
        for (int i = 0; i < MEM_WORDS; i++) begin
            if (i == abort_at) begin
                aborted = 1'b1;
                break;
            end
            sum = (sum + img[i]) % (1 << DATA_W);
            send_word(i, img[i], 1'b1, (i == MEM_WORDS - 1) && !CS_EN);
        end
        if (aborted) begin
            ld_mode = 1'b0;
            tick();
            tick();
            tick();
            check_val("abort_err", int'(ld_error), 1);
            check_val("abort_busy", int'(ld_busy), 0);
            check_val("abort_run", int'(cpu_run), 0);
        end else begin
            if (CS_EN) begin
                send_word(0, bad_cs ? (sum + 1) % (1 << DATA_W) : sum, 1'b0, 1'b0);
            end
            ok = !(CS_EN && bad_cs);
            tick();
            check_val("end_run", int'(cpu_run), int'(ok));
            check_val("end_err", int'(ld_error), int'(!ok));
            check_val("end_busy", int'(ld_busy), 0);
        end
        check_val("writes_done", exp_addr_q.size(), 0);
    endtask

    initial begin
        // Reset with ld_mode low: straight to RUN after settling.
        do_reset(1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("settle_run_low", int'(cpu_run), 0);
        end
        tick();
        check_val("run_after_settle", int'(cpu_run), 1);
        repeat (5) tick();
        check_val("no_we_idle", we_count, 0);

        // ld_mode high from reset: image 0..21 (checksum 7).
        do_reset(1'b1);
        repeat (5) tick();
        check_val("busy_from_reset", int'(ld_busy), 1);
        for (int i = 0; i < MEM_WORDS; i++) img[i] = i;
        base = we_count;
        load_image(MEM_WORDS, 1'b0);
        check_val("we_pulses_22", we_count - base, MEM_WORDS);

        // Reload from RUN: first write lands at address 0.
        start_load(1'b1);
        send_word(0, 17, 1'b1, 1'b0);
        ld_mode = 1'b0;
        repeat (3) tick();
        check_val("abort_after_reload", int'(ld_error), 1);

        // Bad checksum, then recovery by toggling ld_mode.
        if (CS_EN) begin
            start_load(1'b0);
            load_image(MEM_WORDS, 1'b1);
            start_load(1'b0);
            send_word(0, int'($urandom_range(0, 31)), 1'b1, 1'b0);
        end

        // Abort after 5 words, then a long strobe must not write.
        start_load(1'b0);
        for (int i = 0; i < MEM_WORDS; i++) img[i] = int'($urandom_range(0, 31));
        load_image(5, 1'b0);
        base = we_count;
        ld_strobe = 1'b1;
        repeat (20) tick();
        ld_strobe = 1'b0;
        repeat (3) tick();
        check_val("no_we_after_abort", we_count - base, 0);
        check_val("err_holds", int'(ld_error), 1);

        // Reset after 10 words, strobe high during reset.
        start_load(1'b0);
        for (int i = 0; i < 10; i++) send_word(i, img[i], 1'b1, 1'b0);
        base = we_count;
        rst_n = 1'b0;
        ld_strobe = 1'b1;
        tick();
        check_val("midreset_outs", outs(), 0);
        ld_strobe = 1'b0;
        rst_n = 1'b1;
        repeat (6) tick();
        check_val("no_we_from_reset_strobe", we_count - base, 0);
        check_val("busy_after_midreset", int'(ld_busy), 1);

        // Randomised images.
        for (int n = 0; n < 6; n++) begin
            int abort_at;
            bit bad;
            for (int i = 0; i < MEM_WORDS; i++) img[i] = int'($urandom_range(0, 31));
            abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, MEM_WORDS - 1))
                                                   : MEM_WORDS;
            bad = CS_EN ? 1'($urandom_range(0, 1)) : 1'b0;
            start_load(1'b0);
            load_image(abort_at, bad);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
